// File: rtl/fp_mult_param.sv
// Parametrised IEEE-754 multiplier: byte-serial operand load, sliced multiply, RNE rounding, byte-serial result.
// Define FP_MULT_PARAM_SUBNORMAL_EN for gradual underflow; otherwise subnormal inputs and tiny results flush to zero.
module fp_mult_param #(
    parameter int unsigned EXP_W  = 11,
    parameter int unsigned FRAC_W = 52,
    parameter int unsigned MUL_W  = 14
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       IN_VALID,
    output logic       IN_READY,
    input  logic [7:0] DATA_IN,
    output logic       OUT_VALID,
    input  logic       OUT_READY,
    output logic [7:0] DATA_OUT
);
    localparam int unsigned W      = 1 + EXP_W + FRAC_W;
    localparam int unsigned NBYTES = W / 8;
    localparam int unsigned SW     = FRAC_W + 1;
    localparam int unsigned PW     = 2 * SW;
    localparam int unsigned K      = (SW + MUL_W - 1) / MUL_W;
    localparam int unsigned BPW    = K * MUL_W;
    localparam int unsigned EW     = EXP_W + 3;
    localparam int unsigned ICW    = $clog2(2 * NBYTES + 1);
    localparam int unsigned OCW    = $clog2(NBYTES + 1);
    localparam int unsigned MCW    = $clog2(K + 1);
    localparam int unsigned BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int unsigned EMAX   = (1 << EXP_W) - 1;
    localparam logic [W-1:0] QUIET = W'(1) << (FRAC_W - 1);

    typedef enum logic [2:0] {
        S_LOAD, S_UNPACK, S_MULT, S_ROUND, S_PACK, S_SEND
    } state_t;

    state_t               state_q, state_d;
    logic [ICW-1:0]       in_cnt_q, in_cnt_d;
    logic [2*W-1:0]       op_q, op_d;
    logic [OCW-1:0]       out_cnt_q, out_cnt_d;
    logic [W-1:0]         out_sh_q, out_sh_d;
    logic                 in_ready_q, in_ready_d;
    logic                 out_valid_q, out_valid_d;
    logic [7:0]           data_out_q, data_out_d;
    logic                 sign_q, sign_d;
    logic signed [EW-1:0] ea_q, ea_d, eb_q, eb_d;
    logic [SW-1:0]        sig_a_q, sig_a_d;
    logic [BPW-1:0]       sig_b_q, sig_b_d;
    logic [PW-1:0]        prod_q, prod_d;
    logic [MCW-1:0]       mcnt_q, mcnt_d;
    logic [W-1:0]         res_q, res_d;

    // Operand field split and classification
    logic [W-1:0]      a_w, b_w;
    logic              a_s, b_s;
    logic [EXP_W-1:0]  a_e, b_e;
    logic [FRAC_W-1:0] a_f, b_f;
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

    assign a_w = op_q[2*W-1:W];
    assign b_w = op_q[W-1:0];
    assign {a_s, a_e, a_f} = a_w;
    assign {b_s, b_e, b_f} = b_w;
    assign a_inf = (a_e == '1) && (a_f == '0);
    assign b_inf = (b_e == '1) && (b_f == '0);
    assign a_nan = (a_e == '1) && (a_f != '0);
    assign b_nan = (b_e == '1) && (b_f != '0);
`ifdef FP_MULT_PARAM_SUBNORMAL_EN
    assign a_zero = (a_e == '0) && (a_f == '0);
    assign b_zero = (b_e == '0) && (b_f == '0);
`else
    assign a_zero = (a_e == '0);
    assign b_zero = (b_e == '0);
`endif

    // Significand normalisation to 1.f with unbiased exponent
    logic [SW-1:0]        a_sig, b_sig;
    logic signed [EW-1:0] a_exp, b_exp;

`ifdef FP_MULT_PARAM_SUBNORMAL_EN
    localparam int unsigned LZW = $clog2(SW + 1);
    logic [LZW-1:0] a_lzc, b_lzc;

    // Leading zeros of {0, frac}; only meaningful for nonzero subnormal fractions
    always_comb begin : lzc
        a_lzc = '0;
        b_lzc = '0;
        for (int i = 0; i < int'(FRAC_W); i++) begin
            if (a_f[i]) a_lzc = LZW'(int'(FRAC_W) - i);
            if (b_f[i]) b_lzc = LZW'(int'(FRAC_W) - i);
        end
    end

    always_comb begin : normalise
        a_sig = {1'b1, a_f};
        b_sig = {1'b1, b_f};
        a_exp = EW'(a_e) - EW'(BIAS);
        b_exp = EW'(b_e) - EW'(BIAS);
        if (a_e == '0) begin
            a_sig = {1'b0, a_f} << a_lzc;
            a_exp = EW'(1) - EW'(BIAS) - EW'(a_lzc);
        end
        if (b_e == '0) begin
            b_sig = {1'b0, b_f} << b_lzc;
            b_exp = EW'(1) - EW'(BIAS) - EW'(b_lzc);
        end
    end
`else
    always_comb begin : normalise
        a_sig = {1'b1, a_f};
        b_sig = {1'b1, b_f};
        a_exp = EW'(a_e) - EW'(BIAS);
        b_exp = EW'(b_e) - EW'(BIAS);
    end
`endif

    // Product normalisation, optional denormalisation, and round-to-nearest-even
    logic                 pm, tiny, rup;
    logic [PW-1:0]        nrm, dn;
    logic signed [EW-1:0] e_pre, e_fin;
    logic [SW-1:0]        mant;
    logic [SW:0]          sum;
    logic [FRAC_W-1:0]    frac;
    logic [W-1:0]         rnd_res;
`ifdef FP_MULT_PARAM_SUBNORMAL_EN
    localparam int unsigned SHW = $clog2(FRAC_W + 3);
    logic [EW-1:0]  rsh;
    logic [SHW-1:0] sh_amt;
`endif

    always_comb begin : round_dp
        pm      = prod_q[PW-1];
        nrm     = pm ? prod_q : (prod_q << 1);
        e_pre   = ea_q + eb_q + EW'(BIAS) + EW'(pm);
        tiny    = e_pre[EW-1] || (e_pre == '0);
        dn      = nrm;
`ifdef FP_MULT_PARAM_SUBNORMAL_EN
        rsh     = EW'(1) - e_pre;
        sh_amt  = (rsh > EW'(FRAC_W + 2)) ? SHW'(FRAC_W + 2) : SHW'(rsh);
        if (tiny) begin
            dn    = nrm >> sh_amt;
            dn[0] = dn[0] | (|(nrm & ~({PW{1'b1}} << sh_amt)));
        end
`endif
        mant    = dn[PW-1 -: SW];
        rup     = dn[FRAC_W] & (dn[FRAC_W-1] | (|dn[FRAC_W-2:0]) | mant[0]);
        sum     = {1'b0, mant} + (SW+1)'(rup);
        e_fin   = e_pre;
        frac    = sum[FRAC_W-1:0];
        if (tiny) begin
            e_fin = EW'(sum[FRAC_W]);
        end else if (sum[SW]) begin
            e_fin = e_pre + EW'(1);
            frac  = sum[FRAC_W:1];
        end
        rnd_res = {sign_q, e_fin[EXP_W-1:0], frac};
        if ($unsigned(e_fin) >= EW'(EMAX)) rnd_res = {sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
`ifndef FP_MULT_PARAM_SUBNORMAL_EN
        if (tiny) rnd_res = {sign_q, {(W-1){1'b0}}};
`endif
    end

    logic [SW+MUL_W-1:0] part;

    always_comb begin : next_state
        state_d     = state_q;
        in_cnt_d    = in_cnt_q;
        op_d        = op_q;
        out_cnt_d   = out_cnt_q;
        out_sh_d    = out_sh_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        sign_d      = sign_q;
        ea_d        = ea_q;
        eb_d        = eb_q;
        sig_a_d     = sig_a_q;
        sig_b_d     = sig_b_q;
        prod_d      = prod_q;
        mcnt_d      = mcnt_q;
        res_d       = res_q;
        part        = (SW+MUL_W)'(sig_a_q) * (SW+MUL_W)'(sig_b_q[MUL_W-1:0]);

        unique case (state_q)
            S_LOAD: begin
                if (IN_VALID && in_ready_q) begin
                    op_d     = {op_q[2*W-9:0], DATA_IN};
                    in_cnt_d = in_cnt_q + ICW'(1);
                    if (in_cnt_q == ICW'(2 * NBYTES - 1)) begin
                        in_cnt_d   = '0;
                        in_ready_d = 1'b0;
                        state_d    = S_UNPACK;
                    end
                end
            end
            S_UNPACK: begin
                sign_d  = a_s ^ b_s;
                state_d = S_PACK;
                if (a_nan) begin
                    res_d = a_w | QUIET;
                end else if (b_nan) begin
                    res_d = b_w | QUIET;
                end else if ((a_zero && b_inf) || (a_inf && b_zero)) begin
                    res_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};
                end else if (a_inf || b_inf) begin
                    res_d = {a_s ^ b_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
                end else if (a_zero || b_zero) begin
                    res_d = {a_s ^ b_s, {(W-1){1'b0}}};
                end else begin
                    sig_a_d = a_sig;
                    sig_b_d = BPW'(b_sig);
                    ea_d    = a_exp;
                    eb_d    = b_exp;
                    prod_d  = '0;
                    mcnt_d  = '0;
                    state_d = S_MULT;
                end
            end
            // One MUL_W-bit slice of B per cycle, LSB slice first
            S_MULT: begin
                prod_d  = prod_q + (PW'(part) << (MUL_W * mcnt_q));
                sig_b_d = sig_b_q >> MUL_W;
                mcnt_d  = mcnt_q + MCW'(1);
                if (mcnt_q == MCW'(K - 1)) state_d = S_ROUND;
            end
            S_ROUND: begin
                res_d   = rnd_res;
                state_d = S_PACK;
            end
            S_PACK: begin
                out_sh_d    = res_q;
                data_out_d  = res_q[W-1 -: 8];
                out_valid_d = 1'b1;
                out_cnt_d   = '0;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (OUT_READY) begin
                    out_sh_d   = out_sh_q << 8;
                    data_out_d = out_sh_q[W-9 -: 8];
                    out_cnt_d  = out_cnt_q + OCW'(1);
                    if (out_cnt_q == OCW'(NBYTES - 1)) begin
                        out_cnt_d   = '0;
                        data_out_d  = '0;
                        out_valid_d = 1'b0;
                        in_ready_d  = 1'b1;
                        state_d     = S_LOAD;
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= S_LOAD;
            in_cnt_q    <= '0;
            op_q        <= '0;
            out_cnt_q   <= '0;
            out_sh_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            sign_q      <= 1'b0;
            ea_q        <= '0;
            eb_q        <= '0;
            sig_a_q     <= '0;
            sig_b_q     <= '0;
            prod_q      <= '0;
            mcnt_q      <= '0;
            res_q       <= '0;
        end else begin
            state_q     <= state_d;
            in_cnt_q    <= in_cnt_d;
            op_q        <= op_d;
            out_cnt_q   <= out_cnt_d;
            out_sh_q    <= out_sh_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            sign_q      <= sign_d;
            ea_q        <= ea_d;
            eb_q        <= eb_d;
            sig_a_q     <= sig_a_d;
            sig_b_q     <= sig_b_d;
            prod_q      <= prod_d;
            mcnt_q      <= mcnt_d;
            res_q       <= res_d;
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign DATA_OUT  = data_out_q;

endmodule

// File: tb/tb_fp_mult_param.sv
// Bench for fp_mult_param (default binary64 parameters); reference products come from host double arithmetic.
module tb_fp_mult_param;
    logic       CLK = 1'b0;
    logic       RESET;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] DATA_IN;
    logic       OUT_VALID;
    logic       OUT_READY;
    logic [7:0] DATA_OUT;

    int n_assert = 0;
    int n_fail   = 0;

`ifdef FP_MULT_PARAM_SUBNORMAL_EN
    localparam bit FLUSH = 1'b0;
`else
    localparam bit FLUSH = 1'b1;
`endif

    fp_mult_param dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .IN_VALID (IN_VALID),
        .IN_READY (IN_READY),
        .DATA_IN  (DATA_IN),
        .OUT_VALID(OUT_VALID),
        .OUT_READY(OUT_READY),
        .DATA_OUT (DATA_OUT)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: IEEE special-case rules, then host double multiply (RNE, gradual underflow)
    function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b);
        logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s;
        logic [63:0] r;
        a_nan  = (a[62:52] == 11'h7FF) && (a[51:0] != 0);
        b_nan  = (b[62:52] == 11'h7FF) && (b[51:0] != 0);
        a_inf  = (a[62:52] == 11'h7FF) && (a[51:0] == 0);
        b_inf  = (b[62:52] == 11'h7FF) && (b[51:0] == 0);
        a_zero = (a[62:52] == 0) && (FLUSH || a[51:0] == 0);
        b_zero = (b[62:52] == 0) && (FLUSH || b[51:0] == 0);
        s = a[63] ^ b[63];
        if (a_nan) return a | 64'h0008_0000_0000_0000;
        if (b_nan) return b | 64'h0008_0000_0000_0000;
        if ((a_zero && b_inf) || (a_inf && b_zero)) return 64'h7FF8_0000_0000_0000;
        if (a_inf || b_inf) return {s, 11'h7FF, 52'h0};
        if (a_zero || b_zero) return {s, 63'h0};
        r = $realtobits($bitstoreal(a) * $bitstoreal(b));
        if (FLUSH && r[62:52] == 0) return {s, 63'h0};
        return r;
    endfunction

    function automatic logic [63:0] rnd_norm();
        logic [63:0] v;
        logic [63:0] r;
        r = {$urandom, $urandom};
        v[63]    = r[63];
        v[62:52] = 11'(1023 + $urandom_range(1000) - 500);
        v[51:0]  = r[51:0];
        return v;
    endfunction

    task automatic send_op(input logic [63:0] a, input logic [63:0] b, input int max_gap);
        logic [127:0] v;
        int n;
        v = {a, b};
        for (int i = 0; i < 16; i++) begin
            IN_VALID = 1'b0;
            if (max_gap > 0) repeat ($urandom_range(max_gap)) tick();
            n = 0;
            while (!IN_READY && n < 200) begin
                tick();
                n++;
            end
            if (n > 0) chk("in_ready_wait", 64'(IN_READY), 64'd1);
            IN_VALID = 1'b1;
            DATA_IN  = v[127-8*i -: 8];
            tick();
        end
        IN_VALID = 1'b0;
    endtask

    task automatic recv(input string tag, input logic [63:0] exp, input int exp_lat,
                        input int st0, input int st4);
        logic [63:0] got;
        logic [7:0]  eb;
        int lat;
        int stall;
        got = '0;
        lat = 0;
        OUT_READY = (st0 == 0);
        while (!OUT_VALID && lat < 100) begin
            tick();
            lat++;
        end
        if (exp_lat >= 0) chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        for (int j = 0; j < 8; j++) begin
            eb = exp[63-8*j -: 8];
            chk({tag, "/out_valid"}, 64'(OUT_VALID), 64'd1);
            stall = (j == 0) ? st0 : ((j == 4) ? st4 : 0);
            if (stall > 0) begin
                OUT_READY = 1'b0;
                repeat (stall) begin
                    tick();
                    chk({tag, "/hold_data"}, 64'(DATA_OUT), 64'(eb));
                    chk({tag, "/hold_valid"}, 64'(OUT_VALID), 64'd1);
                    chk({tag, "/hold_in_ready"}, 64'(IN_READY), 64'd0);
                end
                OUT_READY = 1'b1;
            end
            got[63-8*j -: 8] = DATA_OUT;
            tick();
        end
        OUT_READY = 1'b1;
        chk(tag, got, exp);
        chk({tag, "/in_ready_after"}, 64'(IN_READY), 64'd1);
        chk({tag, "/out_valid_after"}, 64'(OUT_VALID), 64'd0);
    endtask

    task automatic run(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input int gap,
                       input int st0, input int st4);
        send_op(a, b, gap);
        recv(tag, exp, lat, st0, st4);
    endtask

    initial begin
        logic [63:0] sp [8];
        logic [63:0] a, b;
        int n;
        sp = '{64'h0000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h7FF0_0000_0000_0000,
               64'hFFF0_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF4_0000_0000_0000,
               64'h0000_0000_0000_0123, 64'h800F_FFFF_FFFF_FFFF};
        RESET = 1'b1; IN_VALID = 1'b0; DATA_IN = '0; OUT_READY = 1'b1;
        tick(); tick();
        chk("reset/in_ready", 64'(IN_READY), 64'd1);
        chk("reset/out_valid", 64'(OUT_VALID), 64'd0);
        chk("reset/data_out", 64'(DATA_OUT), 64'd0);
        RESET = 1'b0;
        tick();

        run("basic", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 7, 0, 0, 0);
        run("zero_x_inf", 64'h0000000000000000, 64'h7FF0000000000000, 64'h7FF8000000000000, 2, 0, 0, 0);
        run("nan_a", 64'h7FF0000000000001, rnd_norm(), 64'h7FF8000000000001, 2, 0, 0, 0);
        run("nan_b", 64'h3FF0000000000000, 64'hFFF0000000000010, 64'hFFF8000000000010, 2, 0, 0, 0);
        run("inf_x_fin", 64'hFFF0000000000000, 64'h4000000000000000, 64'hFFF0000000000000, 2, 0, 0, 0);
        run("rne_tie", 64'h3FF0000000000001, 64'h3FF8000000000000, 64'h3FF8000000000002, 7, 0, 0, 0);
        run("overflow", 64'h7FEFFFFFFFFFFFFF, 64'h4000000000000000, 64'h7FF0000000000000, 7, 0, 0, 0);
`ifdef FP_MULT_PARAM_SUBNORMAL_EN
        run("sub_tie_even", 64'h0000000000000001, 64'h3FE0000000000000, 64'h0000000000000000, 7, 0, 0, 0);
        run("sub_round_up", 64'h0000000000000001, 64'h3FF8000000000000, 64'h0000000000000002, 7, 0, 0, 0);
        run("sub_to_normal", 64'h000FFFFFFFFFFFFF, 64'h3FF0000000000001, 64'h0010000000000000, 7, 0, 0, 0);
`else
        run("sub_tie_even", 64'h0000000000000001, 64'h3FE0000000000000, 64'h0000000000000000, 2, 0, 0, 0);
        run("sub_round_up", 64'h0000000000000001, 64'h3FF8000000000000, 64'h0000000000000000, 2, 0, 0, 0);
        run("tiny_flush", 64'h2000000000000000, 64'h9FF0000000000000, 64'h8000000000000000, 7, 0, 0, 0);
`endif

        a = rnd_norm(); b = rnd_norm();
        run("backpressure", a, b, ref_mul(a, b), 7, 0, 5, 5);
        a = rnd_norm(); b = rnd_norm();
        run("b2b_1", a, b, ref_mul(a, b), 7, 3, 0, 0);
        a = rnd_norm(); b = rnd_norm();
        run("b2b_2", a, b, ref_mul(a, b), 7, 3, 0, 0);

        IN_VALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            DATA_IN = 8'($urandom);
            tick();
        end
        IN_VALID = 1'b0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_load/in_ready", 64'(IN_READY), 64'd1);
        chk("rst_load/out_valid", 64'(OUT_VALID), 64'd0);
        run("post_reset", 64'h3FF8000000000000, 64'h4000000000000000, 64'h4008000000000000, 7, 1, 0, 0);

        send_op(rnd_norm(), rnd_norm(), 0);
        tick(); tick(); tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("rst_mult/in_ready", 64'(IN_READY), 64'd1);
        chk("rst_mult/out_valid", 64'(OUT_VALID), 64'd0);

        send_op(64'h3FF8000000000000, 64'h4000000000000000, 0);
        OUT_READY = 1'b0;
        n = 0;
        while (!OUT_VALID && n < 100) begin
            tick();
            n++;
        end
        chk("rst_send/pre_valid", 64'(OUT_VALID), 64'd1);
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        OUT_READY = 1'b1;
        chk("rst_send/in_ready", 64'(IN_READY), 64'd1);
        chk("rst_send/out_valid", 64'(OUT_VALID), 64'd0);
        chk("rst_send/data_out", 64'(DATA_OUT), 64'd0);
        a = rnd_norm(); b = rnd_norm();
        run("post_reset2", a, b, ref_mul(a, b), 7, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            a = rnd_norm(); b = rnd_norm();
            run("rand_norm", a, b, ref_mul(a, b), 7, (t % 3), (t % 5 == 0) ? 2 : 0, (t % 7 == 0) ? 3 : 0);
        end
        for (int t = 0; t < 16; t++) begin
            a = ($urandom_range(1) != 0) ? sp[$urandom_range(7)] : rnd_norm();
            b = ($urandom_range(1) != 0) ? sp[$urandom_range(7)] : rnd_norm();
            run("rand_mixed", a, b, ref_mul(a, b), -1, 1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
